// File: rtl/int_issue_queue.sv
// Integer issue queue: age-ordered shifting reservation station that snoops the CDB
// and hands the oldest operand-ready op to the integer ALU on an issue grant.
module int_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 6,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [TAG_W-1:0]  disp_rd_tag,
  input  logic              disp_rs1_rdy,
  input  logic [TAG_W-1:0]  disp_rs1_tag,
  input  logic [DATA_W-1:0] disp_rs1_data,
  input  logic              disp_rs2_rdy,
  input  logic [TAG_W-1:0]  disp_rs2_tag,
  input  logic [DATA_W-1:0] disp_rs2_data,
  output logic              queue_full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              ready_int,
  input  logic              issue_int,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_op,
  output logic [TAG_W-1:0]  ex_rd_tag,
  output logic [DATA_W-1:0] ex_rs1_data,
  output logic [DATA_W-1:0] ex_rs2_data
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              vld;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  rd;
    logic              r1_rdy;
    logic [TAG_W-1:0]  r1_tag;
    logic [DATA_W-1:0] r1_data;
    logic              r2_rdy;
    logic [TAG_W-1:0]  r2_tag;
    logic [DATA_W-1:0] r2_data;
  } ent_t;

  ent_t           ent_q [DEPTH];
  ent_t           ent_d [DEPTH];
  ent_t           nent;
  logic [CW-1:0]  cnt_q, cnt_d, widx;
  logic [DEPTH-1:0] rdy_vec;
  logic [IW-1:0]  sel;
  logic           fire, acc;

  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++)
      rdy_vec[i] = ent_q[i].vld & ent_q[i].r1_rdy & ent_q[i].r2_rdy;
    for (int i = DEPTH-1; i >= 0; i--)
      if (rdy_vec[i]) sel = IW'(i);
  end

  assign ready_int  = |rdy_vec;
  assign queue_full = (cnt_q == CW'(DEPTH));
  assign fire       = issue_int & ready_int;
  assign acc        = disp_valid & ~queue_full;
  assign widx       = cnt_q - CW'(fire);

  // Incoming entry, with same-cycle CDB forwarding folded in
  always_comb begin
    nent         = '0;
    nent.vld     = 1'b1;
    nent.op      = disp_op;
    nent.rd      = disp_rd_tag;
    nent.r1_rdy  = disp_rs1_rdy;
    nent.r1_tag  = disp_rs1_tag;
    nent.r1_data = disp_rs1_data;
    nent.r2_rdy  = disp_rs2_rdy;
    nent.r2_tag  = disp_rs2_tag;
    nent.r2_data = disp_rs2_data;
    if (cdb_valid && !disp_rs1_rdy && cdb_tag == disp_rs1_tag) begin
      nent.r1_rdy  = 1'b1;
      nent.r1_data = cdb_data;
    end
    if (cdb_valid && !disp_rs2_rdy && cdb_tag == disp_rs2_tag) begin
      nent.r2_rdy  = 1'b1;
      nent.r2_data = cdb_data;
    end
  end

  // Order matters: compact, then insert, then snoop so a wakeup lands on the shifted slot
  always_comb begin
    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    if (fire) begin
      for (int i = 0; i < DEPTH-1; i++)
        if (i >= int'(sel)) ent_d[i] = ent_q[i+1];
      ent_d[DEPTH-1] = '0;
    end
    if (acc)
      for (int i = 0; i < DEPTH; i++)
        if (widx == CW'(i)) ent_d[i] = nent;
    if (cdb_valid)
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_d[i].vld && !ent_d[i].r1_rdy && ent_d[i].r1_tag == cdb_tag) begin
          ent_d[i].r1_rdy  = 1'b1;
          ent_d[i].r1_data = cdb_data;
        end
        if (ent_d[i].vld && !ent_d[i].r2_rdy && ent_d[i].r2_tag == cdb_tag) begin
          ent_d[i].r2_rdy  = 1'b1;
          ent_d[i].r2_data = cdb_data;
        end
      end
    cnt_d = cnt_q + CW'(acc) - CW'(fire);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      cnt_q       <= '0;
      ex_valid    <= 1'b0;
      ex_op       <= '0;
      ex_rd_tag   <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      cnt_q    <= cnt_d;
      ex_valid <= fire;
      if (fire) begin
        ex_op       <= ent_q[sel].op;
        ex_rd_tag   <= ent_q[sel].rd;
        ex_rs1_data <= ent_q[sel].r1_data;
        ex_rs2_data <= ent_q[sel].r2_data;
      end
    end
  end
endmodule

// File: tb/tb_int_issue_queue.sv
// Directed bench for int_issue_queue: expected issues go into a scoreboard queue,
// a negedge monitor pops and compares whenever ex_valid is seen.
module tb_int_issue_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid;
  logic [3:0]  disp_op;
  logic [5:0]  disp_rd_tag;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [5:0]  disp_rs1_tag, disp_rs2_tag;
  logic [31:0] disp_rs1_data, disp_rs2_data;
  logic        queue_full;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        ready_int;
  logic        issue_int;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [5:0]  ex_rd_tag;
  logic [31:0] ex_rs1_data, ex_rs2_data;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  int_issue_queue #(.DEPTH(4), .DATA_W(32), .TAG_W(6), .OP_W(4)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_rd_tag(disp_rd_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_data(disp_rs1_data),
    .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_data(disp_rs2_data),
    .queue_full(queue_full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ready_int(ready_int), .issue_int(issue_int),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd_tag(ex_rd_tag),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every ex_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (!rst && ex_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_ex_valid", 32'(ex_rd_tag), 32'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ex_op", 32'(ex_op), 32'(e.op));
        chk("ex_rd_tag", 32'(ex_rd_tag), 32'(e.rd));
        chk("ex_rs1_data", ex_rs1_data, e.d1);
        chk("ex_rs2_data", ex_rs2_data, e.d2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] op, input logic [5:0] rd,
                      input logic r1, input logic [5:0] t1, input logic [31:0] d1,
                      input logic r2, input logic [5:0] t2, input logic [31:0] d2);
    disp_valid = 1'b1; disp_op = op; disp_rd_tag = rd;
    disp_rs1_rdy = r1; disp_rs1_tag = t1; disp_rs1_data = d1;
    disp_rs2_rdy = r2; disp_rs2_tag = t2; disp_rs2_data = d2;
  endtask

  task automatic issue(input logic [3:0] op, input logic [5:0] rd,
                       input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    e.op = op; e.rd = rd; e.d1 = d1; e.d2 = d2;
    sb.push_back(e);
    issue_int = 1'b1;
  endtask

  task automatic cdb(input logic [5:0] t, input logic [31:0] d);
    cdb_valid = 1'b1; cdb_tag = t; cdb_data = d;
  endtask

  task automatic idle();
    disp_valid = 1'b0; issue_int = 1'b0; cdb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    disp_op = '0; disp_rd_tag = '0; disp_rs1_rdy = 0; disp_rs2_rdy = 0;
    disp_rs1_tag = '0; disp_rs2_tag = '0; disp_rs1_data = '0; disp_rs2_data = '0;
    cdb_tag = '0; cdb_data = '0;
    tick(); tick();
    chk("rst_ready_int", 32'(ready_int), 0);
    chk("rst_queue_full", 32'(queue_full), 0);
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_ex_op", 32'(ex_op), 0);
    rst = 1'b0;
    tick();

    // Issue grant with nothing ready is ignored (monitor catches any pulse)
    issue_int = 1'b1; tick(); idle(); tick();
    chk("idle_grant_ex_valid", 32'(ex_valid), 0);

    // Basic dispatch -> issue
    disp(3, 5, 1, 0, 10, 1, 0, 20); tick(); idle();
    chk("t1_ready", 32'(ready_int), 1);
    issue(3, 5, 10, 20); tick(); idle();
    chk("t1_empty_ready", 32'(ready_int), 0);
    tick();
    chk("t1_pulse_one_cycle", 32'(ex_valid), 0);

    // Operand wakeup via CDB
    disp(1, 7, 1, 0, 1, 0, 9, 0); tick(); idle();
    chk("t2_not_ready", 32'(ready_int), 0);
    cdb(9, 32'h55); #1;
    chk("t2_no_same_cycle_ready", 32'(ready_int), 0);
    tick(); idle();
    chk("t2_woken", 32'(ready_int), 1);
    issue(1, 7, 1, 32'h55); tick(); idle();

    // Fill, drop when full, wake middle entry, compaction
    for (int i = 0; i < 4; i++) begin
      disp(4'(4+i), 6'(10+i), 0, 6'(20+i), 0, 1, 0, 32'h100 + 32'(i)); tick();
    end
    idle();
    chk("t3_full", 32'(queue_full), 1);
    disp(9, 14, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF); tick(); idle();
    chk("t3_still_full", 32'(queue_full), 1);
    chk("t3_dropped_not_ready", 32'(ready_int), 0);
    cdb(22, 32'hA2); tick(); idle();
    chk("t3_wake2", 32'(ready_int), 1);
    issue(6, 12, 32'hA2, 32'h102); tick(); idle();
    chk("t3_not_full", 32'(queue_full), 0);
    cdb(23, 32'hA3); tick(); idle();
    issue(7, 13, 32'hA3, 32'h103); tick(); idle();

    // Both remaining entries ready: oldest first
    cdb(21, 32'hA1); tick();
    cdb(20, 32'hA0); tick(); idle();
    issue(4, 10, 32'hA0, 32'h100); tick();
    issue(5, 11, 32'hA1, 32'h101); tick(); idle();
    chk("t4_empty", 32'(ready_int), 0);

    // Dispatch forwarding from same-cycle CDB
    disp(2, 15, 0, 12, 0, 1, 0, 32'h33); cdb(12, 32'hAA); tick(); idle();
    chk("t5_fwd_ready", 32'(ready_int), 1);
    issue(2, 15, 32'hAA, 32'h33); tick(); idle();

    // Simultaneous issue + dispatch at count 2
    disp(1, 20, 1, 0, 1, 1, 0, 2); tick();
    disp(1, 21, 0, 40, 0, 1, 0, 32'h77); tick(); idle();
    disp(8, 22, 1, 0, 3, 1, 0, 4); issue(1, 20, 1, 2); tick(); idle();
    disp(9, 23, 1, 0, 5, 1, 0, 6); tick();
    disp(10, 24, 0, 41, 0, 1, 0, 7); tick(); idle();
    chk("t6_count_full", 32'(queue_full), 1);
    issue(8, 22, 3, 4); tick(); idle();
    tick();
    chk("t6_d_ready", 32'(ready_int), 1);

    // Asynchronous reset mid-operation
    #2 rst = 1'b1; #1;
    chk("rst2_ready_int", 32'(ready_int), 0);
    chk("rst2_queue_full", 32'(queue_full), 0);
    chk("rst2_ex_valid", 32'(ex_valid), 0);
    chk("rst2_ex_op", 32'(ex_op), 0);
    chk("rst2_ex_rd_tag", 32'(ex_rd_tag), 0);
    chk("rst2_ex_rs1", ex_rs1_data, 0);
    chk("rst2_ex_rs2", ex_rs2_data, 0);
    tick(); rst = 1'b0; tick();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Integer-unit issue queue (reservation station). Sits between the dispatch stage and the integer execution unit.
- Holds dispatched ALU ops and snoops the CDB to capture missing source operands.
- Asserts ready_int to the issue unit when at least one entry has both operands; on issue_int it sends the oldest ready entry to the integer ALU.
- Forms the queue side of the ready/issue handshake the issue unit arbitrates.

Parameters:
- DEPTH, 4, number of queue entries (>=2).
- DATA_W, 32, operand/result width.
- TAG_W, 6, ROB/physical tag width.
- OP_W, 4, ALU opcode width.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-high reset
- disp_valid  input  1  dispatch request this cycle
- disp_op  input  OP_W  ALU opcode
- disp_rd_tag  input  TAG_W  destination tag
- disp_rs1_rdy  input  1  rs1 value present
- disp_rs1_tag  input  TAG_W  rs1 producer tag (used when !disp_rs1_rdy)
- disp_rs1_data  input  DATA_W  rs1 value (used when disp_rs1_rdy)
- disp_rs2_rdy, disp_rs2_tag, disp_rs2_data  input  1/TAG_W/DATA_W  same for rs2
- queue_full  output  1  no free entry; dispatch stalls
- cdb_valid  input  1  CDB broadcast valid
- cdb_tag  input  TAG_W  CDB result tag
- cdb_data  input  DATA_W  CDB result value
- ready_int  output  1  at least one entry ready to execute (to issue unit)
- issue_int  input  1  issue grant from issue unit
- ex_valid  output  1  registered one-cycle pulse: operation sent to ALU
- ex_op  output  OP_W  issued opcode
- ex_rd_tag  output  TAG_W  issued destination tag
- ex_rs1_data, ex_rs2_data  output  DATA_W  issued operands

Behaviour:
- Storage: age-ordered shifting array. Entry 0 is the oldest. count = number of valid entries, 0..DEPTH.
- Per entry: valid, op, rd_tag, rs1_rdy/tag/data, rs2_rdy/tag/data. Entry ready = valid & rs1_rdy & rs2_rdy.
- ready_int is combinational from stored state only: OR of entry-ready bits. A same-cycle CDB match does not raise ready_int; it is visible the next cycle.
- queue_full is combinational: count==DEPTH. It is based on current count only, so a dispatch in the same cycle as an issue while full is still rejected.
- Dispatch: accepted at the clock edge iff disp_valid & !queue_full. The new entry is written at index count, or count-1 if an issue also occurs that cycle.
- Dispatch forwarding: if an operand is not ready and cdb_valid & cdb_tag==that operand's tag in the same cycle, the entry is written with that operand ready and data=cdb_data.
- CDB snoop: every valid entry with operand !rdy and a matching tag captures cdb_data and sets rdy at the edge. Both operands may match the same broadcast. Capture is applied after any compaction shift, so no update is lost.
- Select: sel = lowest index with entry ready; combinational.
- Issue: at the edge where issue_int & ready_int:
  - ex_* <= entry[sel] fields, with ex_valid <= 1.
  - Entries sel+1..count-1 shift down by one; count decrements (net 0 with a simultaneous dispatch).
- Otherwise ex_valid <= 0 and ex_op/ex_rd_tag/ex_rs*_data hold their previous values.
- issue_int while ready_int=0 is ignored: no state change, ex_valid <= 0.
- Issue latency: grant at edge N; ex_valid high during cycle N+1 only. The issue unit's slot-1 reservation matches this.
- disp_valid while full: dropped. The dispatcher must hold the request; the queue does not buffer it.
- Reset (any time, including mid-operation): all entries invalid, count=0, ready_int=0, queue_full=0, ex_valid=0, ex_op/ex_rd_tag/ex_rs1_data/ex_rs2_data=0.
- No flush port; a pipeline flush is performed via rst.

Test Plan:
- After reset, dispatch op=3, rd_tag=5, rs1 ready 10, rs2 ready 20 -> ready_int=1 next cycle. Pulse issue_int -> next cycle ex_valid=1, ex_op=3, ex_rd_tag=5, ex_rs1_data=10, ex_rs2_data=20; queue empty, ready_int=0.
- Dispatch rd_tag=7 with rs2 waiting on tag 9. Hold issue_int=0 -> ready_int=0. Broadcast cdb_tag=9, cdb_data=0x55 -> ready_int=1 the following cycle; issue -> ex_rs2_data=0x55.
- Dispatch 4 entries, none ready -> queue_full=1; a 5th disp_valid is dropped (count stays 4). CDB wakes entry 2; issue -> entry 2 leaves, entries 3->2 shift, queue_full=0.
- Entries 0 and 1 both become ready at the same time -> the first issue sends entry 0 (older); the second issue sends the former entry 1.
- Dispatch whose rs1 tag matches the same-cycle CDB broadcast (tag 12, data 0xAA) -> entry stored ready with rs1 data 0xAA; ready_int=1 next cycle.
- Simultaneous issue and dispatch with count=2 -> count remains 2 and the new entry lands at index 1. Asserting rst mid-sequence -> all outputs return to 0 immediately.
